nvdla_cdp_rdma_req_gen: RTL and testbench

- Parametrised successor of the CDP RDMA ingress request path.
- Walks a 3-D source cube (atoms per line x lines x surfaces) and splits each line into bursts of up to cfg_max_burst+1 atoms.
- Issues memory read requests and pushes one context-queue entry per request.
- Limits outstanding reads with a credit counter sized to the read-latency FIFO. Reports done only after every credit has returned.

---
 rtl/nvdla_cdp_rdma_req_gen.sv | 268 ++++++++++++++++++++++++++
 tb/tb_nvdla_cdp_rdma_req_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_cdp_rdma_req_gen.sv
// -----------------------------------------------------------------------------
// nvdla_cdp_rdma_req_gen
//
// Read-request generator for the CDP RDMA ingress path. Walks a 3-D source cube
// (atoms per line x lines x surfaces), splits every line into bursts of at most
// cfg_max_burst+1 atoms, and for every burst issues one memory read request
// together with one context-queue entry. Outstanding reads are bounded by an
// atom credit counter sized to the downstream read-latency FIFO. Completion is
// signalled only once every credit has come back.
//
// Optional build macro: NVDLA_CDP_RDMA_PERF_EN
//   defined   : perf_stall counts REQ cycles without an issue (saturating),
//               cleared when a new operation is accepted.
//   undefined : perf_stall is tied to zero and no counter is built.
//
// Ports
//   nvdla_core_clk    clock
//   nvdla_core_rstn   asynchronous active-low reset
//   op_start          single-cycle start, honoured only while idle
//   cfg_base_addr     cube base byte address (atom aligned)
//   cfg_line_stride   byte stride between lines
//   cfg_surf_stride   byte stride between surfaces
//   cfg_width         atoms per line minus 1
//   cfg_height        lines per surface minus 1
//   cfg_surfaces      surfaces minus 1
//   cfg_max_burst     maximum burst length in atoms minus 1
//   req_valid/ready   read request handshake
//   req_pd            {size (atoms-1), byte address}
//   cq_wr_pvld/prdy   context queue handshake
//   cq_wr_pd          {line_end, cube_end, size}
//   cdt_lat_fifo_pop  one atom credit returned
//   busy              high whenever not idle
//   done              one-cycle pulse when the operation has fully drained
//   perf_stall        request stall cycle count
// -----------------------------------------------------------------------------
module nvdla_cdp_rdma_req_gen #(
  parameter int AW              = 64,
  parameter int DIM_W           = 13,
  parameter int BURST_W         = 4,
  parameter int CDT_DEPTH       = 64,
  parameter int ATOM_BYTES_LOG2 = 5
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   op_start,
  input  logic [AW-1:0]          cfg_base_addr,
  input  logic [31:0]            cfg_line_stride,
  input  logic [31:0]            cfg_surf_stride,
  input  logic [DIM_W-1:0]       cfg_width,
  input  logic [DIM_W-1:0]       cfg_height,
  input  logic [DIM_W-1:0]       cfg_surfaces,
  input  logic [BURST_W-1:0]     cfg_max_burst,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [AW+BURST_W-1:0]  req_pd,
  output logic                   cq_wr_pvld,
  input  logic                   cq_wr_prdy,
  output logic [BURST_W+1:0]     cq_wr_pd,
  input  logic                   cdt_lat_fifo_pop,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            perf_stall
);

  localparam int CW   = $clog2(CDT_DEPTH + 1);
  localparam int SZW  = BURST_W + 1;
  localparam int CMPW = ((CW > SZW) ? CW : SZW) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CW-1:0]          CRED_FULL   = CW'(CDT_DEPTH);
  localparam logic signed [CMPW:0]   CRED_FULL_S = (CMPW+1)'(CDT_DEPTH);

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic [BURST_W-1:0] burst_size(
    input logic [DIM_W-1:0]   rem,
    input logic [BURST_W-1:0] max_b
  );
    if (DIM_W'(max_b) <= rem) return max_b;
    else                      return rem[BURST_W-1:0];
  endfunction

  // Keeps the counter inside [0, CDT_DEPTH]; an out-of-range sum is a protocol
  // violation that the assertion below reports.
  function automatic logic [CW-1:0] credit_clamp(input logic signed [CMPW:0] v);
    if (v[CMPW])              return '0;
    else if (v > CRED_FULL_S) return CRED_FULL;
    else                      return v[CW-1:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CW-1:0]       credits;
  logic [CW-1:0]       credits_nxt;
  logic                done_nxt;

  logic [DIM_W-1:0]    width_q;
  logic [DIM_W-1:0]    height_q;
  logic [DIM_W-1:0]    surfaces_q;
  logic [BURST_W-1:0]  max_burst_q;
  logic [31:0]         line_stride_q;
  logic [31:0]         surf_stride_q;
  logic [AW-1:0]       line_addr;
  logic [AW-1:0]       surf_addr;
  logic [DIM_W-1:0]    w_cnt;
  logic [DIM_W-1:0]    h_cnt;
  logic [DIM_W-1:0]    s_cnt;

  // ---------------------------------------------------------------------------
  // Request datapath (combinational from current walk position)
  // ---------------------------------------------------------------------------
  logic                in_req;
  logic                start_acc;
  logic [DIM_W-1:0]    rem;
  logic [BURST_W-1:0]  size;
  logic [SZW-1:0]      atoms;
  logic                credit_ok;
  logic                issue;
  logic                line_end;
  logic                last_line;
  logic                last_surf;
  logic                cube_end;
  logic [AW-1:0]       req_addr;
  logic [AW-1:0]       next_surf_addr;
  logic signed [CMPW:0] cred_sum;

  assign in_req    = (state == ST_REQ);
  assign start_acc = (state == ST_IDLE) && op_start;
  assign busy      = (state != ST_IDLE);

  assign rem       = width_q - w_cnt;
  assign size      = burst_size(rem, max_burst_q);
  assign atoms     = SZW'(size) + SZW'(1);
  assign credit_ok = (CMPW'(credits) >= CMPW'(atoms));

  // Request and context entry are coupled so that they always fire together;
  // each side's valid depends only on the other side's ready.
  assign req_valid  = in_req && credit_ok && cq_wr_prdy;
  assign cq_wr_pvld = in_req && credit_ok && req_ready;
  assign issue      = in_req && credit_ok && req_ready && cq_wr_prdy;

  assign line_end  = (DIM_W'(size) == rem);
  assign last_line = (h_cnt == height_q);
  assign last_surf = (s_cnt == surfaces_q);
  assign cube_end  = line_end && last_line && last_surf;

  assign req_addr       = line_addr + (AW'(w_cnt) << ATOM_BYTES_LOG2);
  assign next_surf_addr = surf_addr + AW'(surf_stride_q);

  assign req_pd   = in_req ? {size, req_addr} : '0;
  assign cq_wr_pd = in_req ? {line_end, cube_end, size} : '0;

  // Pop and issue in the same cycle are applied together.
  assign cred_sum = $signed({1'b0, CMPW'(credits)})
                  + $signed({{CMPW{1'b0}}, cdt_lat_fifo_pop})
                  - $signed({1'b0, (issue ? CMPW'(atoms) : CMPW'(0))});
  assign credits_nxt = credit_clamp(cred_sum);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE:  if (op_start)            state_nxt = ST_REQ;
      ST_REQ:   if (issue && cube_end)   state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        // Exit on the cycle the last credit comes home, not one later.
        if (credits_nxt == CRED_FULL) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state   <= ST_IDLE;
      credits <= CRED_FULL;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      credits <= credits_nxt;
      done    <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Cube walk: configuration snapshot, counters and addresses
  // ---------------------------------------------------------------------------
  always_ff @(posedge nvdla_core_clk) begin
    if (start_acc) begin
      width_q       <= cfg_width;
      height_q      <= cfg_height;
      surfaces_q    <= cfg_surfaces;
      max_burst_q   <= cfg_max_burst;
      line_stride_q <= cfg_line_stride;
      surf_stride_q <= cfg_surf_stride;
      line_addr     <= cfg_base_addr;
      surf_addr     <= cfg_base_addr;
      w_cnt         <= '0;
      h_cnt         <= '0;
      s_cnt         <= '0;
    end else if (issue) begin
      if (line_end) begin
        w_cnt <= '0;
        if (last_line) begin
          // Next surface: the line pointer restarts at the new surface base.
          h_cnt     <= '0;
          s_cnt     <= s_cnt + DIM_W'(1);
          surf_addr <= next_surf_addr;
          line_addr <= next_surf_addr;
        end else begin
          h_cnt     <= h_cnt + DIM_W'(1);
          line_addr <= line_addr + AW'(line_stride_q);
        end
      end else begin
        w_cnt <= w_cnt + DIM_W'(atoms);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------------
`ifdef NVDLA_CDP_RDMA_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_cnt <= '0;
    end else if (start_acc) begin
      perf_cnt <= '0;
    end else if (in_req && !issue) begin
      perf_cnt <= sat_inc32(perf_cnt);
    end
  end

  assign perf_stall = perf_cnt;
`else
  assign perf_stall = '0;
`endif

  // ---------------------------------------------------------------------------
  // Credit range check
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_credit_range: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
      (!cred_sum[CMPW]) && (cred_sum <= CRED_FULL_S)
  );
`endif

endmodule

// File: tb/tb_nvdla_cdp_rdma_req_gen.sv
module tb_nvdla_cdp_rdma_req_gen;
  localparam int AW      = 64;
  localparam int DIM_W   = 13;
  localparam int BURST_W = 4;
  localparam int CDT     = 8;
  localparam int ABL     = 5;

`ifdef NVDLA_CDP_RDMA_PERF_EN
  localparam int EXP_PERF = 5;
`else
  localparam int EXP_PERF = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  op_start;
  logic [AW-1:0]         cfg_base_addr;
  logic [31:0]           cfg_line_stride;
  logic [31:0]           cfg_surf_stride;
  logic [DIM_W-1:0]      cfg_width;
  logic [DIM_W-1:0]      cfg_height;
  logic [DIM_W-1:0]      cfg_surfaces;
  logic [BURST_W-1:0]    cfg_max_burst;
  logic                  req_valid;
  logic                  req_ready;
  logic [AW+BURST_W-1:0] req_pd;
  logic                  cq_wr_pvld;
  logic                  cq_wr_prdy;
  logic [BURST_W+1:0]    cq_wr_pd;
  logic                  pop;
  logic                  busy;
  logic                  done;
  logic [31:0]           perf_stall;

  always #5 clk = ~clk;

  nvdla_cdp_rdma_req_gen #(
    .AW(AW), .DIM_W(DIM_W), .BURST_W(BURST_W),
    .CDT_DEPTH(CDT), .ATOM_BYTES_LOG2(ABL)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .op_start         (op_start),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_line_stride  (cfg_line_stride),
    .cfg_surf_stride  (cfg_surf_stride),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .cfg_surfaces     (cfg_surfaces),
    .cfg_max_burst    (cfg_max_burst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_pd           (req_pd),
    .cq_wr_pvld       (cq_wr_pvld),
    .cq_wr_prdy       (cq_wr_prdy),
    .cq_wr_pd         (cq_wr_pd),
    .cdt_lat_fifo_pop (pop),
    .busy             (busy),
    .done             (done),
    .perf_stall       (perf_stall)
  );

  typedef struct {
    logic [AW-1:0]      addr;
    logic [BURST_W-1:0] size;
    logic               le;
    logic               ce;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   issued_atoms = 0;
  int   popped_atoms = 0;
  int   man_target   = 0;
  int   man_done     = 0;
  bit   auto_en      = 1'b1;

  // Monitor: every accepted request is checked against the next expectation.
  always @(negedge clk) begin
    if (rstn && req_valid && req_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_req: got pd=%h cq=%b, nothing expected", req_pd, cq_wr_pd);
      end else begin
        mon_e = sb.pop_front();
        if (!cq_wr_pvld || req_pd !== {mon_e.size, mon_e.addr} ||
            cq_wr_pd !== {mon_e.le, mon_e.ce, mon_e.size}) begin
          bad++;
          $display("FAIL req: got pvld=%b pd=%h cq=%b, want pvld=1 pd=%h cq=%b",
                   cq_wr_pvld, req_pd, cq_wr_pd, {mon_e.size, mon_e.addr},
                   {mon_e.le, mon_e.ce, mon_e.size});
        end
      end
      issued_atoms += int'(req_pd[AW+BURST_W-1:AW]) + 1;
    end
  end

  // Credit return model: explicit pops first, otherwise automatic returns.
  always @(posedge clk) begin
    #2;
    if (man_done < man_target) begin
      pop = 1'b1;
      man_done++;
      popped_atoms++;
    end else if (auto_en && popped_atoms < issued_atoms) begin
      pop = 1'b1;
      popped_atoms++;
    end else begin
      pop = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_req(input logic [AW-1:0] a, input logic [BURST_W-1:0] s,
                            input logic le, input logic ce);
    exp_t e;
    e.addr = a; e.size = s; e.le = le; e.ce = ce;
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [AW-1:0] base, input logic [31:0] ls,
                          input logic [31:0] ss, input logic [DIM_W-1:0] w,
                          input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] s,
                          input logic [BURST_W-1:0] mb);
    cfg_base_addr   = base;
    cfg_line_stride = ls;
    cfg_surf_stride = ss;
    cfg_width       = w;
    cfg_height      = h;
    cfg_surfaces    = s;
    cfg_max_burst   = mb;
    op_start        = 1'b1;
    step();
    op_start        = 1'b0;
    // Configuration must have been captured; scramble it.
    cfg_base_addr   = 64'hFFFF_0000_0000_0000;
    cfg_line_stride = 32'h3;
    cfg_surf_stride = 32'h5;
    cfg_width       = 13'h1FFF;
    cfg_height      = 13'h7;
    cfg_surfaces    = 13'h3;
    cfg_max_burst   = 4'h0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_done: got no done within %0d cycles, want done pulse", name, budget);
    end else begin
      check({name, "_busy_at_done"}, busy, 0);
      step();
      check({name, "_done_width"}, done, 0);
    end
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    rstn = 1'b0; op_start = 1'b0; req_ready = 1'b1; cq_wr_prdy = 1'b1; pop = 1'b0;
    cfg_base_addr = '0; cfg_line_stride = '0; cfg_surf_stride = '0;
    cfg_width = '0; cfg_height = '0; cfg_surfaces = '0; cfg_max_burst = '0;
    step(3);
    check("rst_req_valid", req_valid, 0);
    check("rst_cq_pvld", cq_wr_pvld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req_pd", req_pd, 0);
    check("rst_cq_pd", cq_wr_pd, 0);
    check("rst_perf", perf_stall, 0);
    rstn = 1'b1;
    step(2);

    // One line of 8 atoms in bursts of 4.
    expect_req(64'h1000, 4'd3, 1'b0, 1'b0);
    expect_req(64'h1080, 4'd3, 1'b1, 1'b1);
    cfg_width = 13'd7;
    check("t1_no_valid_before_start", req_valid, 0);
    start_op(64'h1000, 32'h0, 32'h0, 13'd7, 13'd0, 13'd0, 4'd3);
    check("t1_busy", busy, 1);
    wait_done("t1", 100);

    // Two short lines; a second op_start while busy must be ignored.
    expect_req(64'h1000, 4'd4, 1'b1, 1'b0);
    expect_req(64'h1200, 4'd4, 1'b1, 1'b1);
    start_op(64'h1000, 32'h200, 32'h0, 13'd4, 13'd1, 13'd0, 4'd15);
    cfg_base_addr = 64'h8000; cfg_width = 13'd0;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    wait_done("t2", 100);

    // Credit stall: 8-atom bursts with an 8-atom credit pool.
    auto_en = 1'b0;
    expect_req(64'h1000, 4'd7, 1'b0, 1'b0);
    start_op(64'h1000, 32'h0, 32'h0, 13'd15, 13'd0, 13'd0, 4'd7);
    step(4);
    check("t3_stall_no_credit", req_valid, 0);
    man_target += 1;
    step(4);
    check("t3_stall_one_credit", req_valid, 0);
    expect_req(64'h1100, 4'd7, 1'b1, 1'b1);
    man_target += 7;
    auto_en = 1'b1;
    wait_done("t3", 100);

    // Context queue back-pressure for 5 REQ cycles.
    cq_wr_prdy = 1'b0;
    expect_req(64'h1000, 4'd3, 1'b1, 1'b1);
    start_op(64'h1000, 32'h0, 32'h0, 13'd3, 13'd0, 13'd0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      check("t4_no_valid_cq_blocked", req_valid, 0);
      step();
    end
    cq_wr_prdy = 1'b1;
    wait_done("t4", 100);
    check("t4_perf_stall", perf_stall, EXP_PERF);

    // Two lines over two surfaces.
    expect_req(64'h1000,  4'd0, 1'b1, 1'b0);
    expect_req(64'h1400,  4'd0, 1'b1, 1'b0);
    expect_req(64'h11000, 4'd0, 1'b1, 1'b0);
    expect_req(64'h11400, 4'd0, 1'b1, 1'b1);
    start_op(64'h1000, 32'h400, 32'h10000, 13'd0, 13'd1, 13'd1, 4'd0);
    wait_done("t6", 100);

    // Issue coincident with a pop (credits 4 -> 1), then reset in DRAIN.
    auto_en = 1'b0;
    req_ready = 1'b0;
    expect_req(64'h1000, 4'd3, 1'b0, 1'b0);
    expect_req(64'h1080, 4'd3, 1'b0, 1'b0);
    expect_req(64'h1100, 4'd3, 1'b1, 1'b1);
    start_op(64'h1000, 32'h0, 32'h0, 13'd11, 13'd0, 13'd0, 4'd3);
    check("t5_pvld_needs_ready", cq_wr_pvld, 0);
    check("t5_valid_full_credit", req_valid, 1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step(2);
    check("t5_valid_credit4", req_valid, 1);
    req_ready = 1'b1;
    man_target += 1;
    step();
    check("t5_stall_credit1", req_valid, 0);
    man_target += 2;
    step(5);
    check("t5_stall_credit3", req_valid, 0);
    man_target += 1;
    step(3);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_busy_drain", busy, 1);
    rstn = 1'b0;
    step();
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_req_valid", req_valid, 0);
    check("t5_rst_cq_pvld", cq_wr_pvld, 0);
    check("t5_rst_req_pd", req_pd, 0);
    check("t5_rst_cq_pd", cq_wr_pd, 0);
    check("t5_rst_perf", perf_stall, 0);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_no_done_after_rst", done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
